// File: rtl/multdiv_pkg.sv
// Shared types for the multiply/divide sequencer: FSM states, operation
// encoding and iteration counter width.
package multdiv_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    FIX,
    DONE
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/multdiv_ctrl_iter_counter.sv
// Iteration counter for the multiply/divide sequencer; flags the final
// iteration so the FSM can leave RUN.
module iter_counter
  import multdiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  // Clear wins over enable so a restart always begins from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CNT_W'(ITERS - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multicycle multiply/divide datapath. Defining
// MULTDIV_DIV0_BYPASS_EN sends a divide-by-zero straight from LOAD to DONE.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int ITERS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             divisor_zero,
  output logic             dp_load,
  output logic             dp_step,
  output logic             dp_op,
  output logic             dp_fix,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception,
  output logic [CNT_W-1:0] iter
);

  state_t state;
  state_t nextState;
  op_t    opReg;
  logic   div0Reg;
  logic   startAcc;
  logic   bypass;
  logic   cntLast;

  // A multiply outranks a simultaneous divide, so it must not pick up the div0 flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      opReg   <= OP_MULT;
      div0Reg <= 1'b0;
    end else begin
      state <= nextState;
      if (startAcc) begin
        opReg   <= ctrl_MULT ? OP_MULT : OP_DIV;
        div0Reg <= ~ctrl_MULT & ctrl_DIV & divisor_zero;
      end
    end
  end

`ifdef MULTDIV_DIV0_BYPASS_EN
  assign bypass = div0Reg;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    nextState      = state;
    dp_load        = 1'b0;
    dp_step        = 1'b0;
    dp_fix         = 1'b0;
    data_resultRDY = 1'b0;
    startAcc       = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    case (state)
      IDLE: begin
        if (startAcc) nextState = LOAD;
      end
      LOAD: begin
        dp_load   = 1'b1;
        nextState = bypass ? DONE : RUN;
      end
      RUN: begin
        dp_step = 1'b1;
        if (cntLast) nextState = FIX;
      end
      FIX: begin
        dp_fix    = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        data_resultRDY = 1'b1;
        nextState      = startAcc ? LOAD : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy           = (state == LOAD) || (state == RUN) || (state == FIX);
  assign data_exception = data_resultRDY & div0Reg;
  assign dp_op          = opReg;

  // Clearing on the accepted start makes iter read 0 already in the LOAD cycle.
  iter_counter #(
    .ITERS(ITERS)
  ) u_iter_counter (
    .clock (clock),
    .reset (reset),
    .clear (startAcc),
    .enable((state == RUN) && !cntLast),
    .count (iter),
    .last  (cntLast)
  );

endmodule
